// File: rtl/game_sprite_motion_if.sv
// Bus between the game/CPU side and the sprite motion controller.
// Master drives the strobes and load data; the slave publishes the sprite state.
interface game_sprite_motion_if #(
    parameter int X_WIDTH  = 10,
    parameter int Y_WIDTH  = 10,
    parameter int DX_WIDTH = 2,
    parameter int DY_WIDTH = 2
);
    logic                frame_tick;
    logic                motion_en;
    logic                write_xy;
    logic [X_WIDTH-1:0]  x_in;
    logic [Y_WIDTH-1:0]  y_in;
    logic                write_dxdy;
    logic [DX_WIDTH-1:0] dx_in;
    logic [DY_WIDTH-1:0] dy_in;
    logic                sprite_we;
    logic [X_WIDTH-1:0]  sprite_x;
    logic [Y_WIDTH-1:0]  sprite_y;
    logic [DX_WIDTH-1:0] sprite_dx;
    logic [DY_WIDTH-1:0] sprite_dy;
    logic                busy;
    logic                off_screen;

    modport master (
        output frame_tick, motion_en, write_xy, x_in, y_in, write_dxdy, dx_in, dy_in,
        input  sprite_we, sprite_x, sprite_y, sprite_dx, sprite_dy, busy, off_screen
    );

    modport slave (
        input  frame_tick, motion_en, write_xy, x_in, y_in, write_dxdy, dx_in, dy_in,
        output sprite_we, sprite_x, sprite_y, sprite_dx, sprite_dy, busy, off_screen
    );
endinterface

// File: rtl/game_sprite_motion.sv
// Per-sprite motion controller: one signed velocity step per frame tick, with CPU overrides.
// Define GAME_SPRITE_MOTION_BOUNCE_EN to clamp at screen edges and reflect velocity.
module game_sprite_motion #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int SPRITE_WIDTH  = 8,
    parameter int SPRITE_HEIGHT = 8,
    parameter int X_WIDTH       = 10,
    parameter int Y_WIDTH       = 10,
    parameter int DX_WIDTH      = 2,
    parameter int DY_WIDTH      = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    game_sprite_motion_if.slave bus
);
    typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, PUBLISH} state_t;

    localparam logic [X_WIDTH-1:0] X_MAX = X_WIDTH'(SCREEN_WIDTH - SPRITE_WIDTH);
    localparam logic [Y_WIDTH-1:0] Y_MAX = Y_WIDTH'(SCREEN_HEIGHT - SPRITE_HEIGHT);

    state_t              state_q, state_d;
    logic [X_WIDTH-1:0]  x_q, x_d;
    logic [Y_WIDTH-1:0]  y_q, y_d;
    logic [DX_WIDTH-1:0] dx_q, dx_d;
    logic [DY_WIDTH-1:0] dy_q, dy_d;
    logic                we_q, we_d;

    logic [X_WIDTH-1:0]  x_step;
    logic [Y_WIDTH-1:0]  y_step;
    logic [DX_WIDTH-1:0] dx_step;
    logic [DY_WIDTH-1:0] dy_step;

`ifdef GAME_SPRITE_MOTION_BOUNCE_EN
    localparam logic [DX_WIDTH-1:0] DX_MIN = {1'b1, {(DX_WIDTH-1){1'b0}}};
    localparam logic [DY_WIDTH-1:0] DY_MIN = {1'b1, {(DY_WIDTH-1){1'b0}}};

    // Two guard bits so both underflow below 0 and overflow past the edge stay visible.
    logic signed [X_WIDTH+1:0] x_wide;
    logic signed [Y_WIDTH+1:0] y_wide;
    logic [DX_WIDTH-1:0]       dx_neg;
    logic [DY_WIDTH-1:0]       dy_neg;

    assign x_wide = $signed({2'b00, x_q}) + $signed({{(X_WIDTH+2-DX_WIDTH){dx_q[DX_WIDTH-1]}}, dx_q});
    assign y_wide = $signed({2'b00, y_q}) + $signed({{(Y_WIDTH+2-DY_WIDTH){dy_q[DY_WIDTH-1]}}, dy_q});
    // The most negative velocity has no positive twin, so it reflects to the most positive.
    assign dx_neg = (dx_q == DX_MIN) ? ~DX_MIN : (DX_WIDTH'(0) - dx_q);
    assign dy_neg = (dy_q == DY_MIN) ? ~DY_MIN : (DY_WIDTH'(0) - dy_q);

    always_comb begin
        x_step  = x_wide[X_WIDTH-1:0];
        dx_step = dx_q;
        if (x_wide < 0) begin
            x_step  = '0;
            dx_step = dx_neg;
        end else if (x_wide > $signed({2'b00, X_MAX})) begin
            x_step  = X_MAX;
            dx_step = dx_neg;
        end
        y_step  = y_wide[Y_WIDTH-1:0];
        dy_step = dy_q;
        if (y_wide < 0) begin
            y_step  = '0;
            dy_step = dy_neg;
        end else if (y_wide > $signed({2'b00, Y_MAX})) begin
            y_step  = Y_MAX;
            dy_step = dy_neg;
        end
    end
`else
    always_comb begin
        x_step  = x_q + {{(X_WIDTH-DX_WIDTH){dx_q[DX_WIDTH-1]}}, dx_q};
        y_step  = y_q + {{(Y_WIDTH-DY_WIDTH){dy_q[DY_WIDTH-1]}}, dy_q};
        dx_step = dx_q;
        dy_step = dy_q;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            we_q    <= we_d;
        end
    end

    // A position write aborts any step in flight and swallows a coincident tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.frame_tick && bus.motion_en) state_d = STEP_X;
            STEP_X:  state_d = STEP_Y;
            STEP_Y:  state_d = PUBLISH;
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.write_xy) state_d = IDLE;
    end

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        dx_d = dx_q;
        dy_d = dy_q;
        we_d = (state_q == PUBLISH) || bus.write_xy;
        if (!bus.write_xy && state_q == STEP_X) begin
            x_d  = x_step;
            dx_d = dx_step;
        end
        if (!bus.write_xy && state_q == STEP_Y) begin
            y_d  = y_step;
            dy_d = dy_step;
        end
        if (bus.write_xy) begin
            x_d = bus.x_in;
            y_d = bus.y_in;
        end
        // Explicit velocity loads override any reflection computed on the same edge.
        if (bus.write_dxdy) begin
            dx_d = bus.dx_in;
            dy_d = bus.dy_in;
        end
    end

    always_comb begin
        bus.sprite_we  = we_q;
        bus.sprite_x   = x_q;
        bus.sprite_y   = y_q;
        bus.sprite_dx  = dx_q;
        bus.sprite_dy  = dy_q;
        bus.busy       = (state_q != IDLE);
        bus.off_screen = (x_q > X_MAX) || (y_q > Y_MAX);
    end
endmodule

// File: tb/tb_game_sprite_motion.sv
// Directed and randomized checks of game_sprite_motion against a frame-level reference model.
module tb_game_sprite_motion;
    localparam int XW = 10;
    localparam int YW = 10;
    localparam int X_LIM = 640 - 8;
    localparam int Y_LIM = 480 - 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   we_cnt = 0;
    int   mx, my, mdx, mdy;

    game_sprite_motion_if bus ();

    game_sprite_motion dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.sprite_we === 1'b1) we_cnt++;

    // Reference: new coordinate after one frame, wrapping or bouncing.
    function automatic int axis_pos(int p, int v, int w, int lim);
        int n = p + v;
`ifdef GAME_SPRITE_MOTION_BOUNCE_EN
        if (n < 0) return 0;
        if (n > lim) return lim;
        return n;
`else
        return n & ((1 << w) - 1);
`endif
    endfunction

    function automatic int axis_vel(int p, int v, int lim);
`ifdef GAME_SPRITE_MOTION_BOUNCE_EN
        int n = p + v;
        if (n < 0 || n > lim) return (v == -2) ? 1 : -v;
`endif
        return v;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(string tag);
        chk({tag, ".x"}, int'(bus.sprite_x), mx);
        chk({tag, ".y"}, int'(bus.sprite_y), my);
        chk({tag, ".dx"}, int'($signed(bus.sprite_dx)), mdx);
        chk({tag, ".dy"}, int'($signed(bus.sprite_dy)), mdy);
        chk({tag, ".off"}, int'(bus.off_screen), int'(mx > X_LIM || my > Y_LIM));
    endtask

    task automatic load_xy(int x, int y);
        bus.write_xy = 1'b1;
        bus.x_in = XW'(x);
        bus.y_in = YW'(y);
        cyc();
        bus.write_xy = 1'b0;
        cyc();
        mx = x;
        my = y;
    endtask

    task automatic load_v(int dx, int dy);
        bus.write_dxdy = 1'b1;
        bus.dx_in = 2'(dx);
        bus.dy_in = 2'(dy);
        cyc();
        bus.write_dxdy = 1'b0;
        mdx = dx;
        mdy = dy;
    endtask

    task automatic frame(string tag, bit en);
        int w0 = we_cnt;
        int nx, ny;
        bus.frame_tick = 1'b1;
        bus.motion_en = en;
        cyc();
        bus.frame_tick = 1'b0;
        bus.motion_en = 1'b0;
        repeat (4) cyc();
        if (en) begin
            nx = axis_pos(mx, mdx, XW, X_LIM);
            ny = axis_pos(my, mdy, YW, Y_LIM);
            mdx = axis_vel(mx, mdx, X_LIM);
            mdy = axis_vel(my, mdy, Y_LIM);
            mx = nx;
            my = ny;
        end
        check_state(tag);
        chk({tag, ".we_pulses"}, we_cnt - w0, en ? 1 : 0);
        chk({tag, ".busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        int w0;
        bus.frame_tick = 0; bus.motion_en = 0; bus.write_xy = 0; bus.write_dxdy = 0;
        bus.x_in = '0; bus.y_in = '0; bus.dx_in = '0; bus.dy_in = '0;
        mx = 0; my = 0; mdx = 0; mdy = 0;
        #12;
        check_state("reset");
        chk("reset.we", int'(bus.sprite_we), 0);
        chk("reset.busy", int'(bus.busy), 0);
        reset_n = 1'b1;
        cyc();

        // Load pulses sprite_we once.
        w0 = we_cnt;
        load_xy(100, 50);
        chk("load.we_pulses", we_cnt - w0, 1);
        load_v(1, -1);
        check_state("load");

        // Latency walk through a single step.
        bus.frame_tick = 1; bus.motion_en = 1;
        cyc();
        bus.frame_tick = 0; bus.motion_en = 0;
        chk("lat.N.busy", int'(bus.busy), 1);
        chk("lat.N.x", int'(bus.sprite_x), 100);
        cyc();
        chk("lat.N1.x", int'(bus.sprite_x), 101);
        chk("lat.N1.y", int'(bus.sprite_y), 50);
        cyc();
        chk("lat.N2.y", int'(bus.sprite_y), 49);
        chk("lat.N2.we", int'(bus.sprite_we), 0);
        cyc();
        chk("lat.N3.we", int'(bus.sprite_we), 1);
        chk("lat.N3.busy", int'(bus.busy), 0);
        cyc();
        chk("lat.N4.we", int'(bus.sprite_we), 0);
        mx = 101; my = 49;

        frame("disabled", 1'b0);

        // Two back-to-back ticks give one step.
        w0 = we_cnt;
        bus.frame_tick = 1; bus.motion_en = 1;
        repeat (2) cyc();
        bus.frame_tick = 0; bus.motion_en = 0;
        repeat (5) cyc();
        chk("dbl.x", int'(bus.sprite_x), 102);
        chk("dbl.we_pulses", we_cnt - w0, 1);
        mx = 102; my = 48;

        // Position write while in STEP_X aborts the step.
        bus.frame_tick = 1; bus.motion_en = 1;
        cyc();
        bus.frame_tick = 0; bus.motion_en = 0;
        w0 = we_cnt;
        bus.write_xy = 1; bus.x_in = 10'd10; bus.y_in = 10'd20;
        cyc();
        bus.write_xy = 0;
        chk("ovr.x", int'(bus.sprite_x), 10);
        chk("ovr.y", int'(bus.sprite_y), 20);
        chk("ovr.busy", int'(bus.busy), 0);
        chk("ovr.we", int'(bus.sprite_we), 1);
        repeat (4) cyc();
        chk("ovr.x_after", int'(bus.sprite_x), 10);
        chk("ovr.we_pulses", we_cnt - w0, 1);
        mx = 10; my = 20;

        // Write and tick together in IDLE: the write wins.
        bus.frame_tick = 1; bus.motion_en = 1; bus.write_xy = 1;
        bus.x_in = 10'd200; bus.y_in = 10'd300;
        cyc();
        bus.frame_tick = 0; bus.motion_en = 0; bus.write_xy = 0;
        chk("wtick.busy", int'(bus.busy), 0);
        repeat (4) cyc();
        mx = 200; my = 300;
        check_state("wtick");

        // Velocity write on the STEP_X edge: x uses old dx, y uses new dy.
        bus.frame_tick = 1; bus.motion_en = 1;
        cyc();
        bus.frame_tick = 0; bus.motion_en = 0;
        bus.write_dxdy = 1; bus.dx_in = 2'b11; bus.dy_in = 2'b01;
        cyc();
        bus.write_dxdy = 0;
        repeat (3) cyc();
        mx = 201; my = 301; mdx = -1; mdy = 1;
        check_state("vsame");

        // Edge cases: wrap (default) or bounce.
        load_xy(0, 1023);
        load_v(-2, 1);
        frame("edge_lo", 1'b1);
        load_xy(1, 100);
        load_v(-2, 0);
        frame("edge_x1", 1'b1);
        load_xy(632, 471);
        load_v(1, 1);
        frame("edge_hi", 1'b1);

        // Randomized frames.
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0) load_xy(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            if ($urandom_range(0, 1) == 0) load_v(int'($urandom_range(0, 3)) - 2, int'($urandom_range(0, 3)) - 2);
            frame("rand", $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset mid-STEP_Y.
        load_xy(100, 50);
        load_v(1, -1);
        bus.frame_tick = 1; bus.motion_en = 1;
        cyc();
        bus.frame_tick = 0; bus.motion_en = 0;
        cyc();
        #1 reset_n = 1'b0;
        #1;
        mx = 0; my = 0; mdx = 0; mdy = 0;
        check_state("areset");
        chk("areset.we", int'(bus.sprite_we), 0);
        chk("areset.busy", int'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
